// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg: shared constants, stage-depth helpers and address types for the FIFO address controller
package fifo_ctrl_pkg;
  function automatic int max_of(int a, int b);
    return (a > b) ? a : b;
  endfunction
  localparam int S = 7;
  localparam int MUL = 4;
  localparam int MAX_HRS = 1 << (S - 2);
  localparam int A2 = $clog2(max_of(MAX_HRS, MUL));
  localparam int AM = $clog2(MUL - 1);
  function automatic int depth(int i, int hrs = MAX_HRS);
    return max_of(hrs >> i, 1);
  endfunction
  typedef logic [A2-1:0] fifo2_addr_t;
  typedef logic [AM-1:0] fifom_addr_t;
endpackage

// File: rtl/wrap_counter.sv
// wrap_counter: enable-stepped counter 0..DEPTH-1 with sync clear; last flags the wrap value (clk, rst async, clr, en -> cnt, last)
module wrap_counter #(
  parameter int DEPTH = 4,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         last
);
  logic [W-1:0] cnt_q, cnt_d;
  assign last = cnt_q == W'(DEPTH - 1);
  assign cnt_d = clr ? '0 : !en ? cnt_q : last ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/fifo_addr_ctrl.sv
// fifo_addr_ctrl: merges NTT/INTT stage enables, generates per-stage fifo2 and multiplier FIFO addresses, tracks priming and collisions (clk, rst async, clr, ntt_en, intt_en -> stage_en, fifo2_addr, fifom_addr, primed, collide)
module fifo_addr_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int NTT_STAGE_CNT = S,
  parameter int MUL_STAGE_CNT = MUL,
  parameter int NTT_CNT = 1,
  parameter int INTT_CNT = 1,
  localparam int N = NTT_STAGE_CNT,
  localparam int HRS = 1 << (N - 2),
  localparam int W2 = $clog2(max_of(HRS, MUL_STAGE_CNT)),
  localparam int WM = $clog2(MUL_STAGE_CNT - 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic [NTT_CNT-1:0][N-1:0]     ntt_en,
  input  logic [INTT_CNT-1:0][N-1:0]    intt_en,
  output logic [N-1:0]                  stage_en,
  output logic [N-1:0][W2-1:0]          fifo2_addr,
  output logic [WM-1:0]                 fifom_addr,
  output logic [N-1:0]                  primed,
  output logic [N-1:0]                  collide
);
  logic [N-1:0] ntt_m, intt_m, last, primed_q, primed_d, collide_q, collide_d;
  always_comb begin
    ntt_m = '0;
    intt_m = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < NTT_CNT; j++) ntt_m[i] = ntt_m[i] | ntt_en[j][N-1-i];
      for (int j = 0; j < INTT_CNT; j++) intt_m[i] = intt_m[i] | intt_en[j][i];
    end
  end
  assign stage_en = ntt_m | intt_m;
  assign primed_d = clr ? '0 : primed_q | (stage_en & last);
  assign collide_d = clr ? '0 : collide_q | (ntt_m & intt_m);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      primed_q <= '0;
      collide_q <= '0;
    end else begin
      primed_q <= primed_d;
      collide_q <= collide_d;
    end
  for (genvar k = 0; k < N; k++) begin : g_st
    wrap_counter #(.DEPTH(depth(k, HRS)), .W(W2)) u_cnt (
      .clk(clk), .rst(rst), .clr(clr), .en(stage_en[k]), .cnt(fifo2_addr[k]), .last(last[k])
    );
  end
  wrap_counter #(.DEPTH(MUL_STAGE_CNT - 1), .W(WM)) u_mul (
    .clk(clk), .rst(rst), .clr(clr), .en(|stage_en), .cnt(fifom_addr), .last()
  );
  assign primed = primed_q;
  assign collide = collide_q;
endmodule

// File: tb/tb_fifo_addr_ctrl.sv
// tb_fifo_addr_ctrl: directed table and sequence checks for fifo_addr_ctrl
module tb_fifo_addr_ctrl;
  localparam int N = 7;
  logic clk = 0, rst = 1, clr = 0;
  logic [0:0][N-1:0] ntt_en, intt_en;
  logic [N-1:0] stage_en, primed, collide;
  logic [N-1:0][4:0] fifo2_addr;
  logic [1:0] fifom_addr;
  int errors = 0, checks = 0;

  fifo_addr_ctrl dut (
    .clk(clk), .rst(rst), .clr(clr), .ntt_en(ntt_en), .intt_en(intt_en),
    .stage_en(stage_en), .fifo2_addr(fifo2_addr), .fifom_addr(fifom_addr),
    .primed(primed), .collide(collide)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] ntt, intt;
    logic clr;
    logic [N-1:0] se;
    logic [N-1:0][4:0] addr;
    logic [1:0] fm;
    logic [N-1:0] pr, co;
  } vec_t;

  function automatic logic [N-1:0][4:0] mk(int a0, int a1, int a2, int a6);
    logic [N-1:0][4:0] r = '0;
    r[0] = 5'(a0); r[1] = 5'(a1); r[2] = 5'(a2); r[6] = 5'(a6);
    return r;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [N-1:0] n, logic [N-1:0] t, logic c);
    ntt_en[0] = n; intt_en[0] = t; clr = c;
  endtask

  vec_t tbl[9];

  initial begin
    tbl[0] = '{7'b1000000, 7'b0000000, 0, 7'b0000001, mk(1,0,0,0), 2'd1, 7'b0, 7'b0};
    tbl[1] = '{7'b0000000, 7'b0000001, 0, 7'b0000001, mk(2,0,0,0), 2'd2, 7'b0, 7'b0};
    tbl[2] = '{7'b1000000, 7'b0000001, 0, 7'b0000001, mk(3,0,0,0), 2'd0, 7'b0, 7'b0000001};
    tbl[3] = '{7'b0000000, 7'b0000000, 0, 7'b0000000, mk(3,0,0,0), 2'd0, 7'b0, 7'b0000001};
    tbl[4] = '{7'b0000000, 7'b0000010, 0, 7'b0000010, mk(3,1,0,0), 2'd1, 7'b0, 7'b0000001};
    tbl[5] = '{7'b0000001, 7'b0000000, 0, 7'b1000000, mk(3,1,0,0), 2'd2, 7'b1000000, 7'b0000001};
    tbl[6] = '{7'b0000001, 7'b1000000, 0, 7'b1000000, mk(3,1,0,0), 2'd0, 7'b1000000, 7'b1000001};
    tbl[7] = '{7'b0100000, 7'b0000100, 0, 7'b0000110, mk(3,2,1,0), 2'd1, 7'b1000000, 7'b1000001};
    tbl[8] = '{7'b0000000, 7'b0000100, 1, 7'b0000100, mk(0,0,0,0), 2'd0, 7'b0, 7'b0};
    drive('0, '0, 0);
    #12 rst = 0;
    step();
    chk("reset addr", 64'(fifo2_addr), 0);
    chk("reset fifom", 64'(fifom_addr), 0);
    chk("reset primed", 64'(primed), 0);
    chk("reset collide", 64'(collide), 0);
    for (int v = 0; v < 9; v++) begin
      drive(tbl[v].ntt, tbl[v].intt, tbl[v].clr);
      #1 chk($sformatf("v%0d stage_en", v), 64'(stage_en), 64'(tbl[v].se));
      step();
      chk($sformatf("v%0d addr", v), 64'(fifo2_addr), 64'(tbl[v].addr));
      chk($sformatf("v%0d fifom", v), 64'(fifom_addr), 64'(tbl[v].fm));
      chk($sformatf("v%0d primed", v), 64'(primed), 64'(tbl[v].pr));
      chk($sformatf("v%0d collide", v), 64'(collide), 64'(tbl[v].co));
    end
    // stage 0 wrap over 40 cycles, from cleared state
    drive('0, '0, 1); step();
    drive('0, 7'b0000001, 0);
    for (int c = 0; c < 40; c++) begin
      chk($sformatf("wrap addr0 c%0d", c), 64'(fifo2_addr[0]), 64'(c % 32));
      chk($sformatf("wrap fifom c%0d", c), 64'(fifom_addr), 64'(c % 3));
      chk($sformatf("wrap primed0 c%0d", c), 64'(primed[0]), 64'(c >= 32));
      step();
    end
    chk("wrap others", 64'(fifo2_addr[6:1]), 0);
    // depth-1 stage 6
    drive('0, '0, 1); step();
    drive('0, 7'b1000000, 0);
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("d1 addr6 c%0d", c), 64'(fifo2_addr[6]), 0);
      chk($sformatf("d1 primed6 c%0d", c), 64'(primed), 64'(7'b1000000));
    end
    // clr dominates an enable with addr2=5 and collide/primed set
    drive('0, '0, 1); step();
    drive(7'b0010000, 7'b0000100, 0); step();
    drive('0, 7'b0000100, 0);
    for (int c = 0; c < 4; c++) step();
    drive('0, 7'b1000000, 0); step();
    chk("pre-clr addr2", 64'(fifo2_addr[2]), 5);
    chk("pre-clr collide", 64'(collide), 64'(7'b0000100));
    chk("pre-clr primed", 64'(primed), 64'(7'b1000000));
    drive('0, 7'b0000100, 1); step();
    chk("clr addr", 64'(fifo2_addr), 0);
    chk("clr primed", 64'(primed), 0);
    chk("clr collide", 64'(collide), 0);
    chk("clr fifom", 64'(fifom_addr), 0);
    // async reset mid-count with addr1=9
    drive(7'b0100000, 7'b0000010, 0); step();
    drive('0, 7'b0000010, 0);
    for (int c = 0; c < 8; c++) step();
    chk("pre-rst addr1", 64'(fifo2_addr[1]), 9);
    chk("pre-rst collide", 64'(collide), 64'(7'b0000010));
    #1 rst = 1;
    #1;
    chk("rst addr", 64'(fifo2_addr), 0);
    chk("rst fifom", 64'(fifom_addr), 0);
    chk("rst collide", 64'(collide), 0);
    chk("rst primed", 64'(primed), 0);
    chk("rst stage_en", 64'(stage_en), 64'(7'b0000010));
    #1 rst = 0;
    step();
    chk("post-rst addr1", 64'(fifo2_addr[1]), 1);
    chk("post-rst fifom", 64'(fifom_addr), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
